// File: rtl/pea_pkg.sv
// rtl/pea_pkg.sv - shared types and defaults for the PE array feeder
package pea_pkg;

  localparam int ROW_DEF       = 3;
  localparam int COL_DEF       = 10;
  localparam int WGT_WIDTH_DEF = 24;
  localparam int IFM_WIDTH_DEF = 128;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int PE_LAT_DEF    = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    PRIME,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  typedef logic [31:0] sum_t;

  typedef struct packed {
    logic pvalid;
    logic ic_done;
    logic oc_done;
  } marker_t;

endpackage

// File: rtl/pea_marker_pipe.sv
// rtl/pea_marker_pipe.sv - fixed-latency delay line for psum markers
module pea_marker_pipe
  import pea_pkg::*;
#(
  parameter int PE_LAT = PE_LAT_DEF
) (
  input  logic    clk,
  input  logic    rstn,
  input  marker_t i_mark,
  output marker_t o_mark
);

  if (PE_LAT == 0) begin : g_bypass
    assign o_mark = i_mark;
  end else begin : g_pipe
    marker_t r_stage [PE_LAT];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < PE_LAT; i++) r_stage[i] <= '0;
      end else begin
        r_stage[0] <= i_mark;
        for (int i = 1; i < PE_LAT; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_mark = r_stage[PE_LAT-1];
  end

endmodule

// File: rtl/pea_feeder.sv
// rtl/pea_feeder.sv - weight/ifm sequencer and psum marker source for the 3x3 PE array
module pea_feeder
  import pea_pkg::*;
#(
  parameter int ROW       = ROW_DEF,
  parameter int COL       = COL_DEF,
  parameter int WGT_WIDTH = WGT_WIDTH_DEF,
  parameter int IFM_WIDTH = IFM_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int PE_LAT    = PE_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 cfg_stride,
  input  logic [CNT_WIDTH-1:0] cfg_ic,
  input  logic [CNT_WIDTH-1:0] cfg_oc,
  input  logic [CNT_WIDTH-1:0] cfg_ow,
  output logic                 busy,
  output logic                 done,
  input  logic                 wgt_s_valid,
  output logic                 wgt_s_ready,
  input  logic [WGT_WIDTH-1:0] wgt_s_data,
  input  logic                 ifm_s_valid,
  output logic                 ifm_s_ready,
  input  logic [IFM_WIDTH-1:0] ifm_s_data,
  output logic                 stride,
  output logic                 wgt_read,
  output logic [WGT_WIDTH-1:0] wgt_group,
  output logic                 ifm_read,
  output logic [IFM_WIDTH-1:0] ifm_group,
  output logic                 pvalid,
  output logic                 ic_done,
  output logic                 oc_done
);

  localparam int BEAT_W     = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int DRAIN_W    = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam int DRAIN_LAST = (PE_LAT > 0) ? PE_LAT - 1 : 0;

  // Elaboration stops here if one ifm beat cannot hold a full column.
  if (IFM_WIDTH < (ROW + COL - 1) * 8) begin : g_ifm_width_too_small
    pea_feeder_ifm_width_too_small u_err ();
  end

  state_t               r_state, w_state_nxt;
  logic                 r_stride;
  logic [CNT_WIDTH-1:0] r_cfg_ic, r_cfg_oc, r_cfg_ow;
  logic [CNT_WIDTH-1:0] r_ic, r_oc;
  logic [CNT_WIDTH:0]   r_win;
  logic [BEAT_W-1:0]    r_beat;
  logic [1:0]           r_col;
  logic                 r_phase;
  logic [DRAIN_W-1:0]   r_drain;

  logic    w_wgt_hs, w_ifm_hs, w_win_done, w_win_last;
  logic    w_last_beat, w_last_ic, w_last_oc, w_drain_end, w_pass_end;
  marker_t w_mark_in, w_mark_out;

  assign w_wgt_hs    = (r_state == LOAD_W) && wgt_s_valid;
  assign w_ifm_hs    = ((r_state == PRIME) || (r_state == STREAM)) && ifm_s_valid;
  // Stride 2 completes a window on the second column of each pair.
  assign w_win_done  = w_ifm_hs && (((r_state == PRIME) && (r_col == 2'd2)) ||
                                    ((r_state == STREAM) && (!r_stride || r_phase)));
  assign w_win_last  = w_win_done && (r_win == {1'b0, r_cfg_ow});
  assign w_last_beat = (r_beat == BEAT_W'(ROW - 1));
  assign w_last_ic   = (r_ic == r_cfg_ic);
  assign w_last_oc   = (r_oc == r_cfg_oc);
  assign w_drain_end = (r_drain == DRAIN_W'(DRAIN_LAST));
  assign w_pass_end  = ((r_state == DRAIN) && w_drain_end) || ((PE_LAT == 0) && w_win_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (start) w_state_nxt = LOAD_W;
      LOAD_W: if (w_wgt_hs && w_last_beat) w_state_nxt = PRIME;
      PRIME, STREAM: begin
        if (w_win_last) begin
          if (PE_LAT > 0)               w_state_nxt = DRAIN;
          else if (w_last_ic && w_last_oc) w_state_nxt = DONE;
          else                          w_state_nxt = LOAD_W;
        end else if (w_win_done) begin
          w_state_nxt = STREAM;
        end
      end
      DRAIN:  if (w_drain_end) w_state_nxt = (w_last_ic && w_last_oc) ? DONE : LOAD_W;
      DONE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stride <= 1'b0;
      r_cfg_ic <= '0;
      r_cfg_oc <= '0;
      r_cfg_ow <= '0;
      r_ic     <= '0;
      r_oc     <= '0;
      r_win    <= '0;
      r_beat   <= '0;
      r_col    <= '0;
      r_phase  <= 1'b0;
      r_drain  <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stride <= cfg_stride;
      r_cfg_ic <= cfg_ic;
      r_cfg_oc <= cfg_oc;
      r_cfg_ow <= cfg_ow;
      r_ic     <= '0;
      r_oc     <= '0;
      r_win    <= '0;
      r_beat   <= '0;
      r_col    <= '0;
      r_phase  <= 1'b0;
      r_drain  <= '0;
    end else if (w_pass_end) begin
      r_win   <= '0;
      r_col   <= '0;
      r_phase <= 1'b0;
      r_drain <= '0;
      if (!w_last_ic) begin
        r_ic <= r_ic + 1'b1;
      end else if (!w_last_oc) begin
        r_ic <= '0;
        r_oc <= r_oc + 1'b1;
      end
    end else begin
      if (w_wgt_hs) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      if (w_ifm_hs && (r_state == PRIME)) r_col <= r_col + 2'd1;
      if (w_ifm_hs && (r_state == STREAM)) r_phase <= r_stride && !r_phase;
      if (w_win_done) r_win <= r_win + 1'b1;
      if (r_state == DRAIN) r_drain <= r_drain + 1'b1;
    end
  end

  assign w_mark_in.pvalid  = w_win_done;
  assign w_mark_in.ic_done = w_win_done && w_last_ic;
  assign w_mark_in.oc_done = w_win_done && w_last_ic && w_last_oc;

  pea_marker_pipe #(.PE_LAT(PE_LAT)) u_marker_pipe (
    .clk    (clk),
    .rstn   (rstn),
    .i_mark (w_mark_in),
    .o_mark (w_mark_out)
  );

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign stride      = r_stride;
  assign wgt_s_ready = (r_state == LOAD_W);
  assign ifm_s_ready = (r_state == PRIME) || (r_state == STREAM);
  assign wgt_read    = w_wgt_hs;
  assign wgt_group   = w_wgt_hs ? wgt_s_data : '0;
  assign ifm_read    = w_ifm_hs;
  assign ifm_group   = w_ifm_hs ? ifm_s_data : '0;
  assign pvalid      = w_mark_out.pvalid;
  assign ic_done     = w_mark_out.ic_done;
  assign oc_done     = w_mark_out.oc_done;

endmodule

// File: tb/tb_pea_feeder.sv
// tb/tb_pea_feeder.sv - randomized self-checking bench for pea_feeder
module tb_pea_feeder;

  localparam int ROW = 3, COL = 10, WGT_WIDTH = 24, IFM_WIDTH = 128, CNT_WIDTH = 8, PE_LAT = 1;
  localparam int K_W = 0, K_I = 1, K_D = 2, K_E = 3;

  logic                 clk, rstn, start, cfg_stride;
  logic [CNT_WIDTH-1:0] cfg_ic, cfg_oc, cfg_ow;
  logic                 busy, done;
  logic                 wgt_s_valid, wgt_s_ready, ifm_s_valid, ifm_s_ready;
  logic [WGT_WIDTH-1:0] wgt_s_data, wgt_group;
  logic [IFM_WIDTH-1:0] ifm_s_data, ifm_group;
  logic                 stride, wgt_read, ifm_read, pvalid, ic_done, oc_done;

  pea_feeder #(
    .ROW(ROW), .COL(COL), .WGT_WIDTH(WGT_WIDTH), .IFM_WIDTH(IFM_WIDTH),
    .CNT_WIDTH(CNT_WIDTH), .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_stride(cfg_stride),
    .cfg_ic(cfg_ic), .cfg_oc(cfg_oc), .cfg_ow(cfg_ow),
    .busy(busy), .done(done),
    .wgt_s_valid(wgt_s_valid), .wgt_s_ready(wgt_s_ready), .wgt_s_data(wgt_s_data),
    .ifm_s_valid(ifm_s_valid), .ifm_s_ready(ifm_s_ready), .ifm_s_data(ifm_s_data),
    .stride(stride), .wgt_read(wgt_read), .wgt_group(wgt_group),
    .ifm_read(ifm_read), .ifm_group(ifm_group),
    .pvalid(pvalid), .ic_done(ic_done), .oc_done(oc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    bit win;
    bit icd;
    bit ocd;
  } step_t;

  // Reference model: the whole job unrolled into the sequence of handshakes it must take.
  step_t    steps[$];
  bit [2:0] exp_mark[int];
  int  n_vec = 0, n_err = 0;
  int  cyc = 0;
  bit  m_stride = 0;
  int  j_ic, j_oc, j_ow, j_st, j_start, j_wr, j_ir, j_pv, j_extra;
  bit  j_chk_cycles, want_start, job_done, gap;
  int  pw, pi;
  int  jobs_done = 0, done_seen = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic build_job(input int ic, input int oc, input int ow, input int st);
    int ncol;
    ncol = (st != 0) ? 2 * ow + 3 : ow + 3;
    for (int o = 0; o <= oc; o++) begin
      for (int i = 0; i <= ic; i++) begin
        for (int b = 0; b < ROW; b++) steps.push_back('{K_W, 0, 0, 0});
        for (int k = 0; k < ncol; k++) begin
          step_t s;
          s.kind = K_I;
          s.win  = (k >= 2) && (((k - 2) % (st + 1)) == 0);
          s.icd  = s.win && (i == ic);
          s.ocd  = s.icd && (o == oc);
          steps.push_back(s);
        end
        for (int d = 0; d < PE_LAT; d++) steps.push_back('{K_D, 0, 0, 0});
      end
    end
    steps.push_back('{K_E, 0, 0, 0});
  endtask

  task automatic job_end_checks();
    int passes, ncol;
    passes = (j_ic + 1) * (j_oc + 1);
    ncol   = (j_st != 0) ? 2 * j_ow + 3 : j_ow + 3;
    check_val("wgt_read_count", j_wr, passes * ROW);
    check_val("ifm_read_count", j_ir, passes * ncol);
    check_val("pvalid_count", j_pv, passes * (j_ow + 1));
    if (j_chk_cycles)
      check_val("job_cycles", cyc - j_start + 1, passes * (ROW + ncol + PE_LAT) + 2 + j_extra);
    jobs_done++;
    job_done = 1;
  endtask

  task automatic cycle_step();
    step_t h;
    bit idle_now;
    bit [2:0] em;
    @(posedge clk);
    #1;
    idle_now    = (steps.size() == 0);
    wgt_s_valid = ($urandom_range(99) < pw);
    ifm_s_valid = !gap && ($urandom_range(99) < pi);
    wgt_s_data  = WGT_WIDTH'($urandom);
    ifm_s_data  = {$urandom, $urandom, $urandom, $urandom};
    if (!idle_now) begin
      start      = 1'($urandom_range(1));
      cfg_stride = 1'($urandom_range(1));
      cfg_ic     = CNT_WIDTH'($urandom);
      cfg_oc     = CNT_WIDTH'($urandom);
      cfg_ow     = CNT_WIDTH'($urandom);
    end else begin
      start      = want_start;
      cfg_stride = 1'(j_st);
      cfg_ic     = CNT_WIDTH'(j_ic);
      cfg_oc     = CNT_WIDTH'(j_oc);
      cfg_ow     = CNT_WIDTH'(j_ow);
    end
    @(negedge clk);
    h = '{-1, 0, 0, 0};
    if (!idle_now) h = steps[0];
    check_val("busy", busy, !idle_now);
    check_val("wgt_s_ready", wgt_s_ready, h.kind == K_W);
    check_val("ifm_s_ready", ifm_s_ready, h.kind == K_I);
    check_val("done", done, h.kind == K_E);
    check_val("stride", stride, m_stride);
    if (done) done_seen++;
    if (h.kind == K_W && wgt_s_valid) begin
      check_val("wgt_read", wgt_read, 1);
      check_val("wgt_group", wgt_group, wgt_s_data);
      j_wr++;
      void'(steps.pop_front());
    end else begin
      check_val("wgt_read", wgt_read, 0);
      check_val("wgt_group_idle", wgt_group, 0);
    end
    if (h.kind == K_I && ifm_s_valid) begin
      check_val("ifm_read", ifm_read, 1);
      check_val("ifm_group", ifm_group, ifm_s_data);
      if (h.win) exp_mark[cyc + PE_LAT] = {1'b1, h.icd, h.ocd};
      j_ir++;
      void'(steps.pop_front());
    end else begin
      check_val("ifm_read", ifm_read, 0);
      check_val("ifm_group_idle", ifm_group, 0);
    end
    if (h.kind == K_D) void'(steps.pop_front());
    em = exp_mark.exists(cyc) ? exp_mark[cyc] : 3'b000;
    if (exp_mark.exists(cyc)) exp_mark.delete(cyc);
    check_val("markers", {pvalid, ic_done, oc_done}, em);
    if (pvalid) j_pv++;
    if (h.kind == K_E) begin
      void'(steps.pop_front());
      job_end_checks();
    end
    if (idle_now && start) begin
      build_job(int'(cfg_ic), int'(cfg_oc), int'(cfg_ow), int'(cfg_stride));
      m_stride   = cfg_stride;
      j_start    = cyc;
      j_wr = 0; j_ir = 0; j_pv = 0;
      want_start = 0;
    end
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_readys"}, {wgt_s_ready, ifm_s_ready}, 0);
    check_val({tag, "_strobes"}, {wgt_read, ifm_read}, 0);
    check_val({tag, "_wgt_group"}, wgt_group, 0);
    check_val({tag, "_ifm_group"}, ifm_group, 0);
    check_val({tag, "_stride"}, stride, 0);
    check_val({tag, "_markers"}, {pvalid, ic_done, oc_done}, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    start = 1'b1; wgt_s_valid = 1'b1; ifm_s_valid = 1'b1;
    wgt_s_data = '1; ifm_s_data = '1;
    #2;
    check_all_zero(tag);
    steps.delete();
    exp_mark.delete();
    m_stride = 0; want_start = 0; gap = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    start = 1'b0;
  endtask

  task automatic run_job(input int ic, input int oc, input int ow, input int st,
                         input int p_w, input int p_i, input int gap_at, input int abort_at,
                         input bit chk_cycles, input int extra);
    int gap_cnt;
    j_ic = ic; j_oc = oc; j_ow = ow; j_st = st;
    pw = p_w; pi = p_i;
    j_chk_cycles = chk_cycles; j_extra = extra;
    want_start = 1; job_done = 0; gap = 0; gap_cnt = 0;
    for (int n = 0; n < 6000 && !job_done; n++) begin
      if (gap_at >= 0 && j_pv >= gap_at && gap_cnt < 4 && !want_start) begin
        gap = 1;
        gap_cnt++;
      end else begin
        gap = 0;
      end
      if (abort_at >= 0 && j_pv >= abort_at && !want_start) begin
        do_reset("mid_reset");
        return;
      end
      cycle_step();
    end
    gap = 0;
    if (!job_done) begin
      check_val("job_timeout", 0, 1);
      do_reset("timeout_reset");
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; cfg_stride = 1'b0;
    cfg_ic = '0; cfg_oc = '0; cfg_ow = '0;
    wgt_s_valid = 1'b0; ifm_s_valid = 1'b0; wgt_s_data = '0; ifm_s_data = '0;
    pw = 100; pi = 100; gap = 0; want_start = 0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    run_job(0, 0, 9, 0, 100, 100, -1, -1, 1, 0);   // single pass
    run_job(0, 0, 4, 1, 100, 100, -1, -1, 1, 0);   // stride 2
    run_job(2, 1, 0, 0, 100, 100, -1, -1, 1, 0);   // channel loops
    run_job(0, 0, 9, 0, 100, 100, 2, -1, 1, 4);    // 4-cycle ifm gap in STREAM
    run_job(0, 0, 9, 0, 100, 100, -1, 3, 0, 0);    // reset mid-STREAM
    run_job(1, 0, 3, 0, 100, 100, -1, -1, 1, 0);   // clean job after reset
    for (int r = 0; r < 14; r++)
      run_job($urandom_range(2), $urandom_range(2), $urandom_range(6), $urandom_range(1),
              $urandom_range(40, 100), $urandom_range(40, 100), -1, -1, 0, 0);
    repeat (3) cycle_step();
    check_val("done_total", done_seen, jobs_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
